// File: rtl/scalar_fu_arbiter.sv
// scalar_fu_arbiter: round-robin sharing of one scalar FU among NUM_REQ requesters.
// Optional WAIT timeout with error response when SCALAR_FU_ARB_TIMEOUT_EN is defined.
module scalar_fu_arbiter #(
  parameter int WIDTH          = 32,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       resp_valid,
  input  logic [NUM_REQ-1:0]       resp_ready,
  output logic [WIDTH-1:0]         resp_data,
  output logic                     resp_err,
  output logic                     busy,
  output logic [WIDTH-1:0]         fu_a,
  output logic [WIDTH-1:0]         fu_b,
  output logic                     fu_on_off,
  input  logic [WIDTH-1:0]         fu_c,
  input  logic                     fu_ack
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3;
  logic [1:0] state;
  logic [IW-1:0] rr_ptr, grant, sel;
  logic any;
  logic timeout;
  // lowest cyclic offset from rr_ptr wins
  always_comb begin
    sel = rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req_valid[(int'(rr_ptr) + k) % NUM_REQ]) sel = IW'((int'(rr_ptr) + k) % NUM_REQ);
  end
  assign any        = |req_valid;
  assign req_ready  = (state == IDLE && any) ? (NUM_REQ'(1) << sel) : '0;
  assign resp_valid = (state == RESP) ? (NUM_REQ'(1) << grant) : '0;
  assign busy       = state != IDLE;
  assign fu_on_off  = state == ISSUE || state == WAIT;
`ifdef SCALAR_FU_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic err;
  assign timeout  = state == WAIT && !fu_ack && cnt == CW'(TIMEOUT_CYCLES - 1);
  assign resp_err = err;
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (state == ISSUE) cnt <= '0;
      else if (state == WAIT && !fu_ack) cnt <= cnt + 1'b1;
      if (state == WAIT && fu_ack) err <= 1'b0;
      else if (timeout) err <= 1'b1;
    end
  end
`else
  assign timeout  = 1'b0;
  assign resp_err = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant     <= '0;
      fu_a      <= '0;
      fu_b      <= '0;
      resp_data <= '0;
    end else begin
      case (state)
        IDLE: if (any) begin
          grant  <= sel;
          rr_ptr <= (sel == IW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
          fu_a   <= req_a[int'(sel)*WIDTH +: WIDTH];
          fu_b   <= req_b[int'(sel)*WIDTH +: WIDTH];
          state  <= ISSUE;
        end
        ISSUE: state <= WAIT;
        WAIT: if (fu_ack) begin
          resp_data <= fu_c;
          state     <= RESP;
        end else if (timeout) begin
          resp_data <= '0;
          state     <= RESP;
        end
        default: if (resp_ready[grant]) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_scalar_fu_arbiter.sv
// tb_scalar_fu_arbiter: randomized transaction-level check of scalar_fu_arbiter against an adder FU model.
module tb_scalar_fu_arbiter;
  localparam int N = 4, W = 32;
  logic clk = 0, reset = 1;
  logic [N-1:0] req_valid = '0, req_ready, resp_valid, resp_ready = '0;
  logic [N*W-1:0] req_a = '0, req_b = '0;
  logic [W-1:0] resp_data, fu_a, fu_b, fu_c = '0;
  logic resp_err, busy, fu_on_off, fu_ack = 0;
  int fu_lat = 1, fu_cnt = 0, ptr = 0, n_pass = 0, n_tot = 0, g, k;
  logic stall = 0;
  time t_last;

  scalar_fu_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err), .busy(busy), .fu_a(fu_a), .fu_b(fu_b),
    .fu_on_off(fu_on_off), .fu_c(fu_c), .fu_ack(fu_ack)
  );

  always #5 clk = ~clk;

  // adder FU: acks fu_lat cycles after being switched on, drops ack when switched off
  always @(posedge clk) begin
    if (fu_on_off) begin
      fu_cnt <= fu_cnt + 1;
      fu_ack <= !stall && (fu_cnt + 1 >= fu_lat);
      fu_c   <= fu_a + fu_b;
    end else begin
      fu_cnt <= 0;
      fu_ack <= 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic randomize_ops;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = $urandom;
      req_b[i*W +: W] = $urandom;
    end
  endtask

  task automatic pulse_reset;
    reset = 1;
    step();
    reset = 0;
    ptr = 0;
  endtask

  // one full transaction: grant, operands, latency, result, backpressure, release
  task automatic op(input logic [N-1:0] v, input int lat, input int bp, output int go);
    logic [W-1:0] ea, eb;
    int kk;
    fu_lat = lat;
    req_valid = v;
    resp_ready = '0;
    #1;
    go = 0;
    for (int j = N - 1; j >= 0; j--) if (v[(ptr + j) % N]) go = (ptr + j) % N;
    chk("grant", 64'(req_ready), 64'(1) << go);
    chk("idle_busy", 64'(busy), 0);
    ea = req_a[go*W +: W];
    eb = req_b[go*W +: W];
    step();
    t_last = $time;
    ptr = (go + 1) % N;
    req_valid = N'($urandom);
    randomize_ops();
    kk = 1;
    while (resp_valid == '0 && kk < 40) begin
      chk("op_ready_low", 64'(req_ready), 0);
      chk("op_on_off", 64'(fu_on_off), 1);
      if (kk == 1) begin
        chk("fu_a", 64'(fu_a), 64'(ea));
        chk("fu_b", 64'(fu_b), 64'(eb));
      end
      step();
      kk++;
    end
    chk("latency", 64'(kk), 64'(lat + 2));
    chk("resp_valid", 64'(resp_valid), 64'(1) << go);
    chk("resp_data", 64'(resp_data), 64'(W'(ea + eb)));
    chk("resp_err", 64'(resp_err), 0);
    for (int i = 0; i < bp; i++) begin
      resp_ready = N'($urandom) & ~(N'(1) << go);
      step();
      chk("bp_valid", 64'(resp_valid), 64'(1) << go);
      chk("bp_data", 64'(resp_data), 64'(W'(ea + eb)));
      chk("bp_ready_low", 64'(req_ready), 0);
    end
    resp_ready = N'(1) << go;
    step();
    resp_ready = '0;
    chk("back_idle", 64'(busy), 0);
  endtask

  initial begin
    step();
    step();
    reset = 0;
    #1;
    chk("rst_req_ready", 64'(req_ready), 0);
    chk("rst_resp_valid", 64'(resp_valid), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_on_off", 64'(fu_on_off), 0);
    chk("rst_fu_ab", {32'(fu_a), 32'(fu_b)}, 0);
    chk("rst_resp", {32'(resp_data), 31'd0, resp_err}, 0);

    req_a[0 +: W] = 5;
    req_b[0 +: W] = 7;
    op(4'b0001, 1, 0, g);
    req_a[W +: W] = 32'hFFFF_FFFF;
    req_b[W +: W] = 1;
    op(4'b0010, 1, 0, g);

    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      time t0;
      t0 = t_last;
      op(4'b1111, 1, 0, g);
      chk("rr_order", 64'(g), 64'(i % 4));
      if (i > 0) chk("rr_interval", 64'(t_last - t0), 40);
    end

    op(4'b1111, 2, 5, g);

    stall = 1;
    fu_lat = 1;
    req_valid = 4'b0100;
    step();
    req_valid = 4'b0010;
    repeat (3) step();
    pulse_reset();
    chk("rstw_on_off", 64'(fu_on_off), 0);
    chk("rstw_busy", 64'(busy), 0);
    chk("rstw_valid", 64'(resp_valid), 0);
    stall = 0;
    op(4'b1111, 1, 0, g);
    chk("rstw_grant", 64'(g), 0);

    stall = 1;
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    k = 1;
    while (resp_valid == '0 && k < 100) begin
      step();
      k++;
    end
`ifdef SCALAR_FU_ARB_TIMEOUT_EN
    chk("to_cycles", 64'(k), 17);
    chk("to_valid", 64'(resp_valid), 1);
    chk("to_err", 64'(resp_err), 1);
    chk("to_data", 64'(resp_data), 0);
    resp_ready = 4'b0001;
    step();
    resp_ready = '0;
    chk("to_idle", 64'(busy), 0);
    ptr = 1;
`else
    chk("no_to_valid", 64'(resp_valid), 0);
    chk("no_to_busy", 64'(busy), 1);
    pulse_reset();
`endif
    stall = 0;

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        req_valid = '0;
        #1;
        chk("idle_ready", 64'(req_ready), 0);
        chk("idle_busy2", 64'(busy), 0);
        step();
      end
      randomize_ops();
      op(N'($urandom_range(1, 15)), $urandom_range(1, 4), $urandom_range(0, 3), g);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
